mips_load_store_unit: RTL
=========================

Name: mips_load_store_unit

Overview:
- Sits directly upstream of mips_data_memory: turns core load/store requests (byte/half/word, byte-addressed) into word accesses on the data memory port.
- Performs lane selection and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Reports misaligned accesses.
- Accepts one request at a time through a valid/ready handshake and returns one response pulse per request.

Parameters:
- ERR_ON_MISALIGN, 1: 1 = a misaligned request is rejected with resp_err; 0 = the low address bits are cleared and the access proceeds.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid only with resp_valid: misaligned or illegal size
- resp_rdata  out  32  load result, valid only with resp_valid
- mem_address  out  32  word address to data memory = latched addr >> 2
- mem_write_data  out  32  full word to write
- mem_write  out  1  data memory write enable
- mem_read  out  1  data memory read enable
- mem_read_data  in  32  from data memory, combinational on mem_address/mem_read

Behaviour:
- Data memory contract:
  - read_data is valid in the same cycle that mem_read is high.
  - Writes commit at the rising clk edge while mem_write is high.
- Lane mapping is little-endian:
  - Byte k = bits [8k+7:8k], where k = addr[1:0].
  - Half h = bits [16h+15:16h], where h = addr[1].
- Acceptance:
  - Acceptance edge = rising edge with req_valid & req_ready.
  - addr, size, write, unsigned and wdata are latched at that edge; the requester need not hold them afterwards.
- Misaligned conditions:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11.
  - size = 11 is always an error, regardless of ERR_ON_MISALIGN.
- FSM states: IDLE, ERR, LOAD, WSTORE, RMW_RD, RMW_WR, DONE.
- IDLE:
  - req_ready = 1.
  - On acceptance: if misaligned and ERR_ON_MISALIGN = 1, go to ERR.
  - Otherwise: load goes to LOAD; word store goes to WSTORE; byte/half store goes to RMW_RD.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0, no memory access; next state IDLE.
- LOAD:
  - mem_read = 1.
  - Extracted and extended lane is registered into resp_rdata.
  - Next state DONE.
- WSTORE: mem_write = 1, mem_write_data = wdata; next state DONE.
- RMW_RD:
  - mem_read = 1.
  - The merge word is registered: mem_read_data with the target lane replaced by wdata[7:0] or wdata[15:0].
  - Next state RMW_WR.
- RMW_WR: mem_write = 1, mem_write_data = merge word; next state DONE.
- DONE: resp_valid = 1, resp_err = 0; next state IDLE.
- req_ready = 0 in every state except IDLE.
- Response latency (acceptance edge to resp_valid cycle):
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Throughput: next acceptance is possible at the edge ending the response cycle plus one.
- mem_read and mem_write:
  - Decoded from state and ANDed with ~reset.
  - Never both high.
  - A write pending in the reset cycle is suppressed.
- mem_address holds the last latched word address between accesses.
- For stores, resp_rdata = 0.
- Reset values:
  - state = IDLE, so req_ready = 1 on the first cycle after reset;
  - resp_valid = 0, resp_err = 0, resp_rdata = 0;
  - mem_address = 0, mem_write_data = 0, mem_read = 0, mem_write = 0.
- Reset mid-operation: the transaction is dropped and no response is issued.
- req_valid while busy is ignored (not latched).

Decomposition:
- Package mips_lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
- Sub-module mips_load_extend is combinational: (word, addr[1:0], size, unsigned) -> 32-bit extended result. Both the LOAD path and the bench reference model use it.

Test Plan:
- Initial memory word 1 = 0x8070_F00F.
  - lw from byte address 0x4 -> resp_rdata = 0x8070F00F, exactly 2 cycles after acceptance.
  - lb from 0x7 -> 0xFFFFFF80.
  - lbu from 0x7 -> 0x00000080.
  - lh from 0x4 -> 0xFFFFF00F.
- sw 0x0000000F to 0x4 -> one mem_write cycle with mem_address = 1 and data 0x0000000F; a following lw from 0x4 returns 0x0000000F.
- Word 1 = 0x11223344; sb 0xAB to 0x5 -> one mem_read cycle, then one mem_write cycle with data 0x1122AB44; resp_valid 3 cycles after acceptance; no mem_write in any other cycle.
- lh from 0x5 and lw from 0x6 (ERR_ON_MISALIGN = 1) -> resp_valid & resp_err 1 cycle after acceptance, mem_read = mem_write = 0 throughout.
- size = 11 with ERR_ON_MISALIGN = 0 -> resp_err = 1.
- lw from 0x6 with ERR_ON_MISALIGN = 0 -> mem_address = 1, the lw returns word 1.
- Reset asserted during RMW_WR -> mem_write stays 0 that cycle, memory is unchanged, no resp_valid, and req_ready = 1 on the next cycle.
- req_valid held high through a load -> second request accepted only when req_ready = 1 again.
- Back-to-back sw / lw to the same address -> the lw returns the stored value.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, FSM states,
// and the alignment helpers used when a request is accepted.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    LOAD,
    WSTORE,
    RMW_RD,
    RMW_WR,
    DONE
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Clears the offset bits a size cannot use, so a tolerated misaligned
  // access lands on the enclosing naturally aligned lane.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: align_lo = {addr_lo[1], 1'b0};
      SZ_WORD: align_lo = 2'b00;
      default: align_lo = addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_load_extend.sv
// Picks the addressed little-endian byte/half lane out of a memory word and
// sign- or zero-extends it to 32 bits; word accesses pass straight through.
module mips_load_extend
  import mips_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = zero_ext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: result = zero_ext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Load/store unit in front of mips_data_memory: one request at a time,
// lane extraction for loads, read-modify-write for byte/half stores.
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        zero_ext_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic [31:0] load_result;
  logic [31:0] merge_word;

  assign req_ready = (state == IDLE);
  assign req_err   = (req_size == SZ_ILLEGAL) ||
                     ((ERR_ON_MISALIGN != 0) && is_misaligned(req_size, req_addr[1:0]));

  // Gating with reset keeps a write that is in flight from landing in memory.
  assign mem_read  = ((state == LOAD) || (state == RMW_RD)) && !reset;
  assign mem_write = ((state == WSTORE) || (state == RMW_WR)) && !reset;

  mips_load_extend u_load_extend (
    .word     (mem_read_data),
    .addr_lo  (addr_lo_q),
    .size     (size_q),
    .zero_ext (zero_ext_q),
    .result   (load_result)
  );

  // Only byte and half stores reach RMW_RD, so only those two cases matter here.
  always_comb begin
    merge_word = mem_read_data;
    if (size_q == SZ_BYTE)
      merge_word[8*addr_lo_q +: 8] = wdata_q[7:0];
    else if (addr_lo_q[1])
      merge_word[31:16] = wdata_q;
    else
      merge_word[15:0] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      size_q         <= SZ_BYTE;
      addr_lo_q      <= 2'b00;
      zero_ext_q     <= 1'b0;
      wdata_q        <= 16'h0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_address <= {2'b00, req_addr[31:2]};
            size_q      <= req_size;
            addr_lo_q   <= align_lo(req_size, req_addr[1:0]);
            zero_ext_q  <= req_unsigned;
            wdata_q     <= req_wdata[15:0];
            resp_rdata  <= 32'h0;
            if (req_err) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              state          <= WSTORE;
              mem_write_data <= req_wdata;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        ERR: state <= IDLE;
        LOAD: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_rdata <= load_result;
        end
        WSTORE: begin
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        RMW_RD: begin
          state          <= RMW_WR;
          mem_write_data <= merge_word;
        end
        RMW_WR: begin
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
